jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
Upstream stimulus/control stage for the JK flip-flop (jkff_nbk). Accepts 2-bit JK commands over a valid/ready handshake and buffers them in a small FIFO. Drives J/K one command at a time, then checks the flip-flop's Q against an internal reference model and flags mismatches. Intended as the driver and self-checker in front of the JK FF in sim and on-board tests.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
CNT_W, 8, width of the saturating mismatch counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low
en  in  1  run enable; 0 means the FSM does not pop new commands
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (registered, = not full)
cmd  in  2  cmd[1]=J, cmd[0]=K: 00 hold, 01 reset, 10 set, 11 toggle
q_in  in  1  Q fed back from the JK FF
J  out  1  registered J drive
K  out  1  registered K drive
busy  out  1  FSM not in IDLE, or FIFO not empty
exp_q  out  1  reference model of Q
mismatch  out  1  sticky; set on the first failed check
mismatch_cnt  out  CNT_W  saturating count of failed checks
fifo_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0 at a rising edge):
  - J=K=0, exp_q=0, mismatch=0, mismatch_cnt=0.
  - FIFO flushed: fifo_count=0, cmd_ready=1.
  - FSM goes to IDLE.
  - Applies mid-operation too; a command in flight is discarded.
  - The JK FF must be reset in the same window so that Q=0 matches exp_q.
- Push: occurs when cmd_valid && cmd_ready. cmd_ready depends only on registered count, so a pop in the same cycle does not allow a push when full.
- Simultaneous push and pop when not full: count unchanged, order preserved (FIFO).
- FSM states are IDLE, DRIVE, CHECK.
- IDLE:
  - Condition to pop: en=1 and FIFO not empty (cycle n).
  - On pop: J,K <= cmd, go to DRIVE.
- DRIVE (cycle n+1):
  - J/K are visible and the FF samples them at the closing edge.
  - At that same edge, exp_q updates by the JK rule: 00 keep, 01 -> 0, 10 -> 1, 11 -> ~exp_q.
  - J,K <= 0; go to CHECK.
- CHECK (cycle n+2): compare q_in with exp_q.
  - If they differ, at the closing edge: mismatch <= 1 and mismatch_cnt++ (saturates at all-ones).
  - If en=1 and FIFO not empty: pop the next command directly into DRIVE (J,K <= cmd). Otherwise go to IDLE.
- Throughput: 1 command per 2 cycles.
- Latency: 1 cycle from pop to J/K visible; 2 cycles from pop to the check.
- en=0 mid-command: the current DRIVE/CHECK completes; no further pops.
- J and K are never both driven outside DRIVE.
- mismatch clears only on reset.

Optional Feature:
JKSEQ_AUTOSYNC_EN
- Defined: on a failed check, exp_q <= q_in at the CHECK edge. This resynchronises the model so one fault counts once.
- Undefined: exp_q is never altered by checks, so a diverged model keeps mismatching (e.g. on holds and toggles).

Decomposition:
- Package jk_seq_pkg holds:
  - command encodings CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_TOG=2'b11;
  - FSM state encodings ST_IDLE, ST_DRIVE, ST_CHECK.
- Sub-module jk_cmd_fifo (parameter DEPTH; push/pop, data, count, full/empty). The FSM and model stay in the top.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with cmd_valid=1 -> J=K=0, exp_q=0, fifo_count=0, cmd_ready=1, mismatch=0. Nothing is pushed while in reset.
2. Real jkff_nbk connected, en=1, push 10,01,11,11,00 back-to-back -> J/K pulses follow that order on alternating cycles. exp_q after each check is 1,0,1,0,0. mismatch stays 0 and busy drops after the last CHECK.
3. en=0, push 5 commands -> cmd_ready=0 after the 4th, the 5th is not accepted, fifo_count=4. Then set en=1 -> 4 commands issue in order, fifo_count reaches 0 after 8 cycles.
4. q_in tied 0, push 10 then 00:
   - first check fails (mismatch=1, mismatch_cnt=1);
   - with JKSEQ_AUTOSYNC_EN, cnt stays 1 after the 00;
   - without it, cnt becomes 2.
5. Assert rst=0 during DRIVE with 3 commands queued -> next edge: J=K=0, fifo_count=0, IDLE, exp_q=0.
6. CNT_W=4, q_in tied 0 without autosync, push 10 then twenty 00 commands -> mismatch_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK command sequencer: command codes, FSM states
// and the JK next-state rule used by the reference model.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_TOG  = 2'b11
  } jk_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } seq_state_e;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      CMD_HOLD: return q;
      CMD_RST:  return 1'b0;
      CMD_SET:  return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// First-word-fall-through command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module jk_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [1:0]               i_wdata,
  output logic [1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands, pulses them onto J/K one at a time and checks the fed-back Q
// against a reference model. Optional macro JKSEQ_AUTOSYNC_EN resyncs the model on a failed check.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd,
  input  logic                   q_in,
  output logic                   J,
  output logic                   K,
  output logic                   busy,
  output logic                   exp_q,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic             r_j;
  logic             r_k;
  logic             r_exp_q;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_jk_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_fail;
  logic [1:0]       w_fifo_rdata;
  logic             w_full;
  logic             w_empty;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (cmd),
    .o_rdata (w_fifo_rdata),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_jk_nxt    = 2'b00;
    case (r_state)
      ST_IDLE, ST_CHECK: begin
        if (en && !w_empty) begin
          w_pop       = 1'b1;
          w_jk_nxt    = w_fifo_rdata;
          w_state_nxt = ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_CHECK;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_fail = (r_state == ST_CHECK) && (q_in != r_exp_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_exp_q    <= 1'b0;
      r_mismatch <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      {r_j, r_k}   <= w_jk_nxt;
      // The model advances at the same edge the flip-flop samples J/K.
      if (r_state == ST_DRIVE) r_exp_q <= jk_next(r_exp_q, {r_j, r_k});
      if (w_fail) begin
        r_mismatch <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
`ifdef JKSEQ_AUTOSYNC_EN
        r_exp_q <= q_in;
`else
        r_exp_q <= r_exp_q;
`endif
      end
    end
  end

  assign J            = r_j;
  assign K            = r_k;
  assign exp_q        = r_exp_q;
  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_cnt;
  assign busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop in the loop
// and a scoreboard of per-command expectations.
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       tie0 = 1'b0;
  logic       ff_q;
  logic       q_in;

  logic       cmd_ready, J, K, busy, exp_q, mismatch;
  logic [7:0] mismatch_cnt;
  logic [2:0] fifo_count;
  logic       cmd_ready_4, J_4, K_4, busy_4, exp_q_4, mismatch_4;
  logic [3:0] mismatch_cnt_4;
  logic [2:0] fifo_count_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .q_in(q_in), .J(J), .K(K), .busy(busy), .exp_q(exp_q),
    .mismatch(mismatch), .mismatch_cnt(mismatch_cnt), .fifo_count(fifo_count)
  );

  jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
    .cmd(cmd), .q_in(q_in), .J(J_4), .K(K_4), .busy(busy_4), .exp_q(exp_q_4),
    .mismatch(mismatch_4), .mismatch_cnt(mismatch_cnt_4), .fifo_count(fifo_count_4)
  );

  // Behavioural JK flip-flop standing in for jkff_nbk, reset alongside the DUT.
  always @(posedge clk) begin
    if (!rst) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b00: ff_q <= ff_q;
        2'b01: ff_q <= 1'b0;
        2'b10: ff_q <= 1'b1;
        2'b11: ff_q <= ~ff_q;
      endcase
    end
  end
  assign q_in = tie0 ? 1'b0 : ff_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic jk_rule(input logic q, input logic [1:0] c);
    logic r;
    if (c == 2'b00) r = q;
    else if (c == 2'b01) r = 1'b0;
    else if (c == 2'b10) r = 1'b1;
    else r = !q;
    return r;
  endfunction

  typedef struct {
    logic [1:0] c;
    logic       e;
    logic [7:0] n;
    logic       m;
  } sb_t;

  sb_t        sbq[$];
  sb_t        cur;
  logic       m_q = 1'b0;
  logic       m_exp = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_mis = 1'b0;
  logic       pend_chk = 1'b0;
  logic       pend_cnt = 1'b0;

  task automatic model_push(input logic [1:0] c);
    sb_t s;
    m_q   = tie0 ? 1'b0 : jk_rule(m_q, c);
    m_exp = jk_rule(m_exp, c);
    s.c = c;
    s.e = m_exp;
    if (m_q != m_exp) begin
      m_mis = 1'b1;
      if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
`ifdef JKSEQ_AUTOSYNC_EN
      m_exp = m_q;
`endif
    end
    s.n = m_cnt;
    s.m = m_mis;
    sbq.push_back(s);
  endtask

  // Scoreboard consumer: J/K in DRIVE, exp_q in CHECK, counters one cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      pend_chk = 1'b0;
      pend_cnt = 1'b0;
    end else begin
      if (pend_cnt) begin
        check("mismatch_cnt", mismatch_cnt, cur.n);
        check("mismatch", mismatch, cur.m);
        pend_cnt = 1'b0;
      end
      if (pend_chk) begin
        check("exp_q_check", exp_q, cur.e);
        pend_cnt = 1'b1;
        pend_chk = 1'b0;
      end
      if (dut.r_state == ST_DRIVE) begin
        if (sbq.size() == 0) check("sb_underflow", sbq.size(), 1);
        else begin
          cur = sbq.pop_front();
          check("jk_drive", {J, K}, cur.c);
          pend_chk = 1'b1;
        end
      end else begin
        check("jk_quiet", {J, K}, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    int t = 0;
    cmd = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin
      tick(1);
      t++;
    end
    if (!cmd_ready) check("send_timeout", cmd_ready, 1);
    else begin
      @(posedge clk);
      model_push(c);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      tick(1);
      t++;
    end
    check("idle_timeout", busy, 0);
    tick(2);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    tick(n);
    sbq.delete();
    m_q = 1'b0; m_exp = 1'b0; m_cnt = 8'd0; m_mis = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with a command offered
    cmd = 2'b10;
    cmd_valid = 1'b1;
    tick(2);
    check("rst_jk", {J, K}, 0);
    check("rst_exp_q", exp_q, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_mismatch", mismatch, 0);
    check("rst_cnt", mismatch_cnt, 0);
    check("rst_busy", busy, 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    check("post_rst_count", fifo_count, 0);

    // 2: real flip-flop in the loop, back-to-back commands
    en = 1'b1;
    send(2'b10); send(2'b01); send(2'b11); send(2'b11); send(2'b00);
    wait_idle();
    check("t2_mismatch", mismatch, 0);
    check("t2_exp_q", exp_q, 0);
    check("t2_sb_drained", sbq.size(), 0);

    // 3: fill with en=0, then drain
    do_reset(1);
    en = 1'b0;
    send(2'b11); send(2'b10); send(2'b01); send(2'b00);
    check("t3_full_ready", cmd_ready, 0);
    check("t3_full_count", fifo_count, 4);
    cmd = 2'b11;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    check("t3_fifth_rejected", fifo_count, 4);
    en = 1'b1;
    tick(6);
    check("t3_count_6", fifo_count, 1);
    tick(2);
    check("t3_count_8", fifo_count, 0);
    wait_idle();

    // 4: Q stuck at 0, set then hold
    tie0 = 1'b1;
    do_reset(1);
    send(2'b10); send(2'b00);
    wait_idle();
    check("t4_mismatch", mismatch, 1);
`ifdef JKSEQ_AUTOSYNC_EN
    check("t4_cnt", mismatch_cnt, 1);
`else
    check("t4_cnt", mismatch_cnt, 2);
`endif

    // 5: reset during DRIVE with three commands queued
    tie0 = 1'b0;
    do_reset(1);
    en = 1'b0;
    send(2'b10); send(2'b11); send(2'b01); send(2'b00);
    en = 1'b1;
    tick(1);
    check("t5_in_drive_count", fifo_count, 3);
    rst = 1'b0;
    tick(1);
    check("t5_jk", {J, K}, 0);
    check("t5_count", fifo_count, 0);
    check("t5_exp_q", exp_q, 0);
    check("t5_busy", busy, 0);
    sbq.delete();
    m_q = 1'b0; m_exp = 1'b0; m_cnt = 8'd0; m_mis = 1'b0;
    rst = 1'b1;
    tick(2);
    check("t5_stays_idle", busy, 0);

    // 6: saturation of a 4-bit counter
    en = 1'b0;
    tie0 = 1'b1;
    do_reset(1);
    en = 1'b1;
    send(2'b10);
    repeat (20) send(2'b00);
    wait_idle();
    check("t6_mismatch4", mismatch_4, 1);
`ifdef JKSEQ_AUTOSYNC_EN
    check("t6_cnt8", mismatch_cnt, 1);
    check("t6_cnt4", mismatch_cnt_4, 1);
`else
    check("t6_cnt8", mismatch_cnt, 21);
    check("t6_cnt4", mismatch_cnt_4, 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
